cga_vram_arbiter: RTL and testbench

//  Time-division arbiter for the single 8-bit video SRAM. It shares the RAM between

---
 rtl/cga_vram_arbiter_pkg.sv | 20 ++
 rtl/cga_vram_slot_timer.sv | 43 ++++
 rtl/cga_vram_arbiter.sv | 159 +++++++++++++++
 tb/tb_cga_vram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cga_vram_arbiter_pkg.sv
// Shared grant encoding and default frame geometry for the CGA video-RAM arbiter.
package cga_vram_arbiter_pkg;

  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_VIDEO  = 2'd1,
    GRANT_CPU_RD = 2'd2,
    GRANT_CPU_WR = 2'd3
  } grant_e;

  localparam int         DEF_SLOT_CYCLES = 4;
  localparam int         DEF_NUM_SLOTS   = 4;
  localparam logic [7:0] DEF_VIDEO_MASK  = 8'h03;

  function automatic logic is_video_slot(input logic [7:0] mask, input logic [2:0] slot,
                                         input logic en);
    return mask[slot] & en;
  endfunction

endpackage

// File: rtl/cga_vram_slot_timer.sv
// Free-running slot timer: cyc 0..SLOT_CYCLES-1, slot 0..NUM_SLOTS-1, never stalls.
// Strobes decode the current count; o_next_slot is the slot that follows the current one.
module cga_vram_slot_timer #(
  parameter int SLOT_CYCLES = 4,
  parameter int NUM_SLOTS   = 4,
  parameter int CW          = $clog2(SLOT_CYCLES)
) (
  input  logic          i_clk,
  input  logic          i_rst_l,
  output logic [CW-1:0] o_cyc,
  output logic [2:0]    o_slot,
  output logic [2:0]    o_next_slot,
  output logic          o_slot_start,
  output logic          o_slot_end
);

  logic [CW-1:0] r_cyc;
  logic [2:0]    r_slot;
  logic          w_end;
  logic [2:0]    w_next_slot;

  assign w_end       = (r_cyc == CW'(SLOT_CYCLES - 1));
  assign w_next_slot = (r_slot == 3'(NUM_SLOTS - 1)) ? 3'd0 : r_slot + 3'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      r_cyc  <= '0;
      r_slot <= '0;
    end else if (w_end) begin
      r_cyc  <= '0;
      r_slot <= w_next_slot;
    end else begin
      r_cyc <= r_cyc + CW'(1);
    end
  end

  assign o_cyc        = r_cyc;
  assign o_slot       = r_slot;
  assign o_next_slot  = w_next_slot;
  assign o_slot_start = (r_cyc == '0);
  assign o_slot_end   = w_end;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Time-division arbiter sharing the 8-bit video SRAM between video fetch and ISA CPU accesses.
// Grants are made on the edge entering cycle 0 of a slot; results strobe in cycle 0 of the next slot.
module cga_vram_arbiter
  import cga_vram_arbiter_pkg::*;
#(
  parameter int         SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int         NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter logic [7:0] VIDEO_MASK  = DEF_VIDEO_MASK
) (
  input  logic        i_clk,
  input  logic        i_busreset_l,
  input  logic        i_vid_en,
  input  logic [18:0] i_vid_addr,
  output logic [7:0]  o_vid_data,
  output logic        o_vid_valid,
  output logic [2:0]  o_vid_slot,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [18:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic        o_cpu_rdy,
  output logic [18:0] o_ram_a,
  output logic        o_ram_we_l,
  output logic [7:0]  o_ram_d_out,
  output logic        o_ram_d_oe,
  input  logic [7:0]  i_ram_d_in
);

  localparam int CW = $clog2(SLOT_CYCLES);

  logic [CW-1:0] w_cyc;
  logic [2:0]    w_slot;
  logic [2:0]    w_next_slot;
  logic          w_slot_start;
  logic          w_slot_end;
  logic          w_req_rise;
  logic          w_vid_grant;

  grant_e        r_grant;
  logic          r_req_d;
  logic          r_cpu_pending;
  logic          r_cpu_we;
  logic [18:0]   r_cpu_addr;
  logic [7:0]    r_cpu_wdata;
  logic [7:0]    r_cpu_rdata;
  logic          r_cpu_ack;
  logic          r_cpu_rdy;
  logic [7:0]    r_vid_data;
  logic          r_vid_valid;
  logic [2:0]    r_vid_slot;
  logic [18:0]   r_ram_a;
  logic          r_ram_we_l;
  logic [7:0]    r_ram_d_out;
  logic          r_ram_d_oe;

  cga_vram_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .NUM_SLOTS  (NUM_SLOTS),
    .CW         (CW)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_l     (i_busreset_l),
    .o_cyc       (w_cyc),
    .o_slot      (w_slot),
    .o_next_slot (w_next_slot),
    .o_slot_start(w_slot_start),
    .o_slot_end  (w_slot_end)
  );

  assign w_req_rise  = i_cpu_req & ~r_req_d;
  assign w_vid_grant = is_video_slot(VIDEO_MASK, w_next_slot, i_vid_en);

  always_ff @(posedge i_clk) begin
    if (!i_busreset_l) begin
      r_grant       <= GRANT_IDLE;
      r_req_d       <= 1'b0;
      r_cpu_pending <= 1'b0;
      r_cpu_we      <= 1'b0;
      r_cpu_addr    <= '0;
      r_cpu_wdata   <= '0;
      r_cpu_rdata   <= '0;
      r_cpu_ack     <= 1'b0;
      r_cpu_rdy     <= 1'b1;
      r_vid_data    <= '0;
      r_vid_valid   <= 1'b0;
      r_vid_slot    <= '0;
      r_ram_a       <= '0;
      r_ram_we_l    <= 1'b1;
      r_ram_d_out   <= '0;
      r_ram_d_oe    <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_req_d     <= i_cpu_req;

      // Write pulse spans cycles 1..SLOT_CYCLES-2 so address and data bracket it by a cycle.
      if (w_slot_start && r_grant == GRANT_CPU_WR) r_ram_we_l <= 1'b0;
      if (w_cyc == CW'(SLOT_CYCLES - 2))          r_ram_we_l <= 1'b1;

      if (w_slot_end) begin
        case (r_grant)
          GRANT_VIDEO: begin
            r_vid_data  <= i_ram_d_in;
            r_vid_valid <= 1'b1;
            r_vid_slot  <= w_slot;
          end
          GRANT_CPU_RD: begin
            r_cpu_rdata <= i_ram_d_in;
            r_cpu_ack   <= 1'b1;
            r_cpu_rdy   <= ~r_cpu_pending;
          end
          GRANT_CPU_WR: begin
            r_cpu_ack <= 1'b1;
            r_cpu_rdy <= ~r_cpu_pending;
          end
          default: ;
        endcase

        if (w_vid_grant) begin
          r_grant    <= GRANT_VIDEO;
          r_ram_a    <= i_vid_addr;
          r_ram_d_oe <= 1'b0;
        end else if (r_cpu_pending) begin
          r_grant       <= r_cpu_we ? GRANT_CPU_WR : GRANT_CPU_RD;
          r_ram_a       <= r_cpu_addr;
          r_ram_d_out   <= r_cpu_wdata;
          r_ram_d_oe    <= r_cpu_we;
          r_cpu_pending <= 1'b0;
        end else begin
          r_grant    <= GRANT_IDLE;
          r_ram_d_oe <= 1'b0;
        end
      end

      // A second edge while one access is already waiting is dropped.
      if (w_req_rise && !r_cpu_pending) begin
        r_cpu_we      <= i_cpu_we;
        r_cpu_addr    <= i_cpu_addr;
        r_cpu_wdata   <= i_cpu_wdata;
        r_cpu_pending <= 1'b1;
        r_cpu_rdy     <= 1'b0;
      end
    end
  end

  assign o_vid_data  = r_vid_data;
  assign o_vid_valid = r_vid_valid;
  assign o_vid_slot  = r_vid_slot;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdy   = r_cpu_rdy;
  assign o_ram_a     = r_ram_a;
  assign o_ram_we_l  = r_ram_we_l;
  assign o_ram_d_out = r_ram_d_out;
  assign o_ram_d_oe  = r_ram_d_oe;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with an async-SRAM model (write commits on we_l rise while data driven).
module tb_cga_vram_arbiter;

  logic        clk;
  logic        busreset_l;
  logic        vid_en;
  logic [18:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [2:0]  vid_slot;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_rdy;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic [7:0]  ram_d_in;

  cga_vram_arbiter dut (
    .i_clk       (clk),
    .i_busreset_l(busreset_l),
    .i_vid_en    (vid_en),
    .i_vid_addr  (vid_addr),
    .o_vid_data  (vid_data),
    .o_vid_valid (vid_valid),
    .o_vid_slot  (vid_slot),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_rdy   (cpu_rdy),
    .o_ram_a     (ram_a),
    .o_ram_we_l  (ram_we_l),
    .o_ram_d_out (ram_d_out),
    .o_ram_d_oe  (ram_d_oe),
    .i_ram_d_in  (ram_d_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= busreset_l ? cycle + 1 : 0;

  logic [7:0] mem [0:524287];
  bit         mem_loaded = 1'b0;
  logic       we_l_q = 1'b1;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem[19'h00100] <= 8'h41;
      mem[19'h00200] <= 8'h00;
      mem[19'h00040] <= 8'hC3;
      mem[19'h00300] <= 8'h00;
      mem[19'h7FFFF] <= 8'h00;
      mem_loaded     <= 1'b1;
    end else if (ram_we_l && !we_l_q && ram_d_oe) begin
      mem[ram_a] <= ram_d_out;
    end
    we_l_q   <= ram_we_l;
    ram_d_in <= mem[ram_a];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cycle, act, exp);
    end
  endtask

  task automatic wait_cycle(input int c);
    chk("schedule", 32'(cycle <= c), 32'd1);
    while (cycle < c) @(negedge clk);
  endtask

  typedef struct {
    int          cyc;
    logic        ven, req, we;
    logic [18:0] addr;
    logic [7:0]  wdat;
    logic        we_l, oe, rdy, ack, vv;
    logic [2:0]  vslot;
    logic [7:0]  rdat;
    logic        achk;
    logic [18:0] a;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int c, input logic ven, input logic req, input logic we,
                     input logic [18:0] addr, input logic [7:0] wd,
                     input logic wel, input logic oe, input logic rdy, input logic ack,
                     input logic vv, input logic [2:0] vs, input logic [7:0] rd,
                     input logic achk, input logic [18:0] a);
    vec_t v;
    v = '{c, ven, req, we, addr, wd, wel, oe, rdy, ack, vv, vs, rd, achk, a};
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  int acks;
  int we_lows;

  initial begin
    //  cyc  ven   req   we    addr      wdat    we_l  oe    rdy   ack   vv    vslot rdata  achk  ram_a
    add(16, 1'b1, 1'b0, 1'b0, 19'h00000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 19'h00100);
    add(17, 1'b1, 1'b1, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(18, 1'b1, 1'b1, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(20, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 19'h00100);
    add(24, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 19'h00200);
    add(25, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 19'h00200);
    add(26, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(27, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(28, 1'b1, 1'b0, 1'b1, 19'h00200, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 19'h00200);
    add(40, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 19'h00100);
    add(41, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(42, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(44, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 19'h00200);
    add(47, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 19'h00000);
    add(48, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h5A, 1'b1, 19'h00100);
    add(52, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h5A, 1'b1, 19'h00100);
    add(56, 1'b0, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h5A, 1'b1, 19'h00100);
    add(60, 1'b0, 1'b1, 1'b0, 19'h00040, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b1, 19'h00100);
    add(61, 1'b0, 1'b0, 1'b0, 19'h00040, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b0, 19'h00000);
    add(62, 1'b0, 1'b1, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b0, 19'h00000);
    add(63, 1'b0, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b0, 19'h00000);
    add(64, 1'b0, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b1, 19'h00040);
    add(68, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'hC3, 1'b1, 19'h00040);
    add(72, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hC3, 1'b1, 19'h00040);
    add(76, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hC3, 1'b0, 19'h00000);

    busreset_l = 1'b0;
    vid_en     = 1'b1;
    vid_addr   = 19'h00100;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_l",  32'(ram_we_l),  32'd1);
    chk("rst_oe",    32'(ram_d_oe),  32'd0);
    chk("rst_rdy",   32'(cpu_rdy),   32'd1);
    chk("rst_ack",   32'(cpu_ack),   32'd0);
    chk("rst_vv",    32'(vid_valid), 32'd0);
    chk("rst_ram_a", 32'(ram_a),     32'h0);
    chk("rst_vdata", 32'(vid_data),  32'h0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_vslot", 32'(vid_slot),  32'h0);
    busreset_l = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      wait_cycle(tbl[i].cyc);
      chk("we_l",  32'(ram_we_l),  32'(tbl[i].we_l));
      chk("oe",    32'(ram_d_oe),  32'(tbl[i].oe));
      chk("rdy",   32'(cpu_rdy),   32'(tbl[i].rdy));
      chk("ack",   32'(cpu_ack),   32'(tbl[i].ack));
      chk("vvalid", 32'(vid_valid), 32'(tbl[i].vv));
      chk("rdata", 32'(cpu_rdata), 32'(tbl[i].rdat));
      if (tbl[i].vv) begin
        chk("vdata", 32'(vid_data), 32'h41);
        chk("vslot", 32'(vid_slot), 32'(tbl[i].vslot));
      end
      if (tbl[i].achk) chk("ram_a", 32'(ram_a), 32'(tbl[i].a));
      vid_en    = tbl[i].ven;
      cpu_req   = tbl[i].req;
      cpu_we    = tbl[i].we;
      cpu_addr  = tbl[i].addr;
      cpu_wdata = tbl[i].wdat;
    end

    // Write at the top of the address space: no wrap, latency edge(81) -> ack(92).
    wait_cycle(81);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_wdata = 8'hA5;
    wait_cycle(83);
    cpu_req = 1'b0;
    wait_cycle(88);
    chk("top_addr", 32'(ram_a), 32'h7FFFF);
    for (int i = 0; i < 16; i++) begin
      if (cpu_ack) break;
      @(negedge clk);
    end
    chk("top_ack_cycle", 32'(cycle), 32'd92);
    chk("mem_7ffff", 32'(mem[19'h7FFFF]), 32'hA5);
    chk("mem_200",   32'(mem[19'h00200]), 32'h5A);

    // Reset landing in write cycle 1 must abort the pulse and drop the access.
    wait_cycle(97);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00300; cpu_wdata = 8'h77;
    wait_cycle(99);
    cpu_req = 1'b0;
    wait_cycle(104);
    chk("mw_oe",   32'(ram_d_oe), 32'd1);
    chk("mw_addr", 32'(ram_a),    32'h300);
    wait_cycle(105);
    chk("mw_we_l_low", 32'(ram_we_l), 32'd0);
    busreset_l = 1'b0;
    @(negedge clk);
    chk("mw_rst_we_l", 32'(ram_we_l), 32'd1);
    chk("mw_rst_oe",   32'(ram_d_oe), 32'd0);
    chk("mw_rst_rdy",  32'(cpu_rdy),  32'd1);
    chk("mw_rst_ack",  32'(cpu_ack),  32'd0);
    repeat (2) @(negedge clk);
    busreset_l = 1'b1;
    acks    = 0;
    we_lows = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (!ram_we_l) we_lows++;
    end
    chk("mw_no_ack",    32'(acks),    32'd0);
    chk("mw_no_we",     32'(we_lows), 32'd0);
    chk("mw_mem_300",   32'(mem[19'h00300]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
